// File: rtl/scm_fifo_ctrl_1r_1w.sv
// Valid/ready FIFO controller around a 1R/1W SCM; out_data_o is the SCM ReadData directly.
// Optional synchronous flush port enabled by defining SCM_FIFO_FLUSH_EN.

module register_file_1r_1w #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  ReadEnable,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [DATA_WIDTH-1:0] WriteData
);
  localparam int NUM_WORDS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;

  // Read address is held while ReadEnable is low, keeping ReadData stable.
  always_comb raddr_d = ReadEnable ? ReadAddr : raddr_q;

  always_ff @(posedge clk) begin
    raddr_q <= raddr_d;
    if (WriteEnable) mem_q[WriteAddr] <= WriteData;
  end

  assign ReadData = mem_q[raddr_q];
endmodule

module scm_fifo_ctrl_1r_1w #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SCM_FIFO_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH:0]   count_o
);
  localparam int NUM_WORDS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = NUM_WORDS[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d, avail_q, avail_d;
  logic                  out_valid_q, out_valid_d;
  logic                  clr, push, issue, pop;

  logic                  scm_we, scm_re;
  logic [ADDR_WIDTH-1:0] scm_waddr, scm_raddr;

`ifdef SCM_FIFO_FLUSH_EN
  assign clr = rst | flush_i;
`else
  assign clr = rst;
`endif

  assign in_ready_o  = (count_q != FULL_CNT);
  assign out_valid_o = out_valid_q;
  assign count_o     = count_q;

  assign push  = in_valid_i & in_ready_o & ~clr;
  assign issue = (avail_q != '0) & (~out_valid_q | out_ready_i) & ~clr;
  assign pop   = out_valid_q & out_ready_i;

  assign scm_we    = push;
  assign scm_waddr = wptr_q;
  assign scm_re    = issue;
  assign scm_raddr = rptr_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    avail_d     = avail_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      avail_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push)  wptr_d = wptr_q + 1'b1;
      if (issue) rptr_d = rptr_q + 1'b1;
      // The displayed slot stays counted until popped, so the writer cannot reach it.
      count_d = count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
      // A written word becomes readable one cycle after its push.
      avail_d = avail_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
      if (issue)    out_valid_d = 1'b1;
      else if (pop) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    wptr_q      <= wptr_d;
    rptr_q      <= rptr_d;
    count_q     <= count_d;
    avail_q     <= avail_d;
    out_valid_q <= out_valid_d;
  end

  register_file_1r_1w #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_scm (
    .clk         (clk),
    .ReadEnable  (scm_re),
    .ReadAddr    (scm_raddr),
    .ReadData    (out_data_o),
    .WriteEnable (scm_we),
    .WriteAddr   (scm_waddr),
    .WriteData   (in_data_i)
  );
endmodule

// File: tb/tb_scm_fifo_ctrl_1r_1w.sv
// Directed bench for scm_fifo_ctrl_1r_1w with a 4-entry SCM.
module tb_scm_fifo_ctrl_1r_1w;
  localparam int AW = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
`ifdef SCM_FIFO_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [DW-1:0] rx_q[$];
  int            rxc_q[$];
  int            collisions = 0;
  int            max_count  = 0;

  scm_fifo_ctrl_1r_1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SCM_FIFO_FLUSH_EN
    .flush_i     (flush),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .count_o     (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pop monitor and invariant tracking, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      rx_q.push_back(out_data);
      rxc_q.push_back(cyc);
    end
    if (dut.scm_we && dut.scm_re && dut.scm_waddr == dut.scm_raddr) collisions++;
    if (int'(count) > max_count) max_count = int'(count);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    @(negedge clk);
    total++; if (count !== 3'd0)   $display("FAIL reset_count got %0d exp 0", count); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    int c0;
    rx_q.delete(); rxc_q.delete();
    c0 = cyc;
    in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (count !== 3'd1 || out_valid !== 1'b0)
      $display("FAIL single_c1 got count=%0d valid=%b exp 1/0", count, out_valid); else passed++;
    step();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== 32'hA5)
      $display("FAIL single_c2 got valid=%b data=%h exp 1/a5", out_valid, out_data); else passed++;
    step();
    @(negedge clk);
    total++; if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL single_c3 got count=%0d valid=%b exp 0/0", count, out_valid); else passed++;
    step();
    total++; if (rx_q.size() != 1 || rxc_q[0] != c0 + 2)
      $display("FAIL single_latency got n=%0d cyc=%0d exp 1/%0d", rx_q.size(),
               rxc_q.size() ? rxc_q[0] - c0 : -1, 2); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    int stable_bad = 0;
    rx_q.delete(); rxc_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = (k < 4) ? DW'(k + 1) : 32'h99;
      @(negedge clk);
      if (k >= 2 && (out_valid !== 1'b1 || out_data !== 32'd1)) stable_bad++;
      if (k >= 4) begin
        total++; if (count !== 3'd4 || in_ready !== 1'b0)
          $display("FAIL fill_full_k%0d got count=%0d ready=%b exp 4/0", k, count, in_ready); else passed++;
      end
      step();
    end
    total++; if (stable_bad != 0) $display("FAIL fill_stable got %0d bad cycles exp 0", stable_bad); else passed++;
  endtask

  task automatic test_full_pop();
    int bad = 0;
    in_valid = 1'b1; in_data = 32'd5; out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL fullpop_refuse got ready=%b exp 0", in_ready); else passed++;
    step();
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || count !== 3'd3)
      $display("FAIL fullpop_accept got ready=%b count=%0d exp 1/3", in_ready, count); else passed++;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    for (int i = 0; i < rx_q.size() && i < 5; i++) if (rx_q[i] !== DW'(i + 1)) bad++;
    total++; if (rx_q.size() != 5 || bad != 0)
      $display("FAIL fullpop_order got n=%0d bad=%0d exp 5/0", rx_q.size(), bad); else passed++;
    total++; if (count !== 3'd0) $display("FAIL fullpop_drain got count=%0d exp 0", count); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    int c0, dbad = 0, cbad = 0, rbad = 0;
    rx_q.delete(); rxc_q.delete();
    c0 = cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      @(negedge clk);
      if (in_ready !== 1'b1) rbad++;
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    for (int i = 0; i < rx_q.size() && i < 10; i++) begin
      if (rx_q[i] !== DW'(i)) dbad++;
      if (rxc_q[i] != c0 + 2 + i) cbad++;
    end
    total++; if (rx_q.size() != 10 || dbad != 0)
      $display("FAIL stream_data got n=%0d bad=%0d exp 10/0", rx_q.size(), dbad); else passed++;
    total++; if (cbad != 0) $display("FAIL stream_timing got %0d late words exp 0", cbad); else passed++;
    total++; if (rbad != 0) $display("FAIL stream_ready got %0d stalls exp 0", rbad); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    int sent = 0, cycles = 0, bad = 0;
    rx_q.delete(); rxc_q.delete();
    collisions = 0; max_count = 0;
    while (rx_q.size() < 1000 && cycles < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end
      step();
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
    total++; if (rx_q.size() != 1000 || bad != 0)
      $display("FAIL random_scoreboard got n=%0d bad=%0d exp 1000/0", rx_q.size(), bad); else passed++;
    total++; if (max_count > 4) $display("FAIL random_max_count got %0d exp <=4", max_count); else passed++;
    total++; if (collisions != 0) $display("FAIL random_collision got %0d exp 0", collisions); else passed++;
  endtask

  task automatic test_mid_clear(input bit use_flush);
    int c0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = DW'(32'h11 * (i + 1));
      step();
    end
    in_valid = 1'b0;
`ifdef SCM_FIFO_FLUSH_EN
    if (use_flush) begin
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hEE;
    end else rst = 1'b1;
`else
    rst = 1'b1;
`endif
    @(negedge clk);
    total++; if (count !== 3'd3) $display("FAIL mid_pre_count got %0d exp 3", count); else passed++;
    step();
    rst = 1'b0;
`ifdef SCM_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    rx_q.delete(); rxc_q.delete();
    c0 = cyc;
    in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b1;
    @(negedge clk);
    total++; if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL mid_clear_f%0d got count=%0d valid=%b exp 0/0", use_flush, count, out_valid); else passed++;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    total++; if (rx_q.size() != 1 || rx_q[0] !== 32'h7 || rxc_q[0] != c0 + 2)
      $display("FAIL mid_next_push_f%0d got n=%0d data=%h dcyc=%0d exp 1/7/2", use_flush, rx_q.size(),
               rx_q.size() ? rx_q[0] : '0, rxc_q.size() ? rxc_q[0] - c0 : -1); else passed++;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_stream();
    test_random();
    test_mid_clear(1'b0);
`ifdef SCM_FIFO_FLUSH_EN
    test_mid_clear(1'b1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
